// File: rtl/alarm_bank.sv
// Bank of N_ALARMS BCD alarm slots with validated loads, per-slot enables and a
// ring / snooze / timeout state machine advanced by the one-minute strobe.
module alarm_bank #(
  parameter int N_ALARMS     = 4,
  parameter int SLOT_W       = 2,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_new_alarm,
  input  logic [SLOT_W-1:0] load_slot,
  input  logic [3:0]        new_alarm_ms_hr,
  input  logic [3:0]        new_alarm_ls_hr,
  input  logic [3:0]        new_alarm_ms_min,
  input  logic [3:0]        new_alarm_ls_min,
  input  logic              enable_wr,
  input  logic              enable_val,
  input  logic [SLOT_W-1:0] read_slot,
  input  logic [3:0]        current_time_ms_hr,
  input  logic [3:0]        current_time_ls_hr,
  input  logic [3:0]        current_time_ms_min,
  input  logic [3:0]        current_time_ls_min,
  input  logic              one_minute,
  input  logic              stop_alarm,
  input  logic              snooze,
  output logic [3:0]        alarm_time_ms_hr,
  output logic [3:0]        alarm_time_ls_hr,
  output logic [3:0]        alarm_time_ms_min,
  output logic [3:0]        alarm_time_ls_min,
  output logic              alarm_ring,
  output logic [SLOT_W-1:0] ring_slot,
  output logic              load_ack,
  output logic              load_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam logic [3:0] SNOOZE_LEN = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIMIT = 4'(RING_TIMEOUT);

  logic [15:0]         slot_q [N_ALARMS];
  logic [N_ALARMS-1:0] en_q;
  logic [15:0]         rd_q, rd_d;
  logic                ack_q, err_q;

  state_e              state_q;
  logic                ring_q;
  logic [SLOT_W-1:0]   ring_slot_q;
  logic [3:0]          ring_cnt_q;
  logic [3:0]          snooze_cnt_q;

  logic [15:0]         new_time, cur_time;
  logic                load_slot_ok, digits_ok, load_valid, disarm_ring;
  logic                match_hit;
  logic [SLOT_W-1:0]   match_idx;

  assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
  assign cur_time = {current_time_ms_hr, current_time_ls_hr,
                     current_time_ms_min, current_time_ls_min};

  // Legal 24 h BCD time: 00:00 .. 23:59.
  assign digits_ok = (new_alarm_ms_hr <= 4'd2) && (new_alarm_ls_hr <= 4'd9) &&
                     !((new_alarm_ms_hr == 4'd2) && (new_alarm_ls_hr > 4'd3)) &&
                     (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);

  assign load_valid  = load_new_alarm && load_slot_ok && digits_ok;
  assign disarm_ring = !load_new_alarm && enable_wr && !enable_val &&
                       (load_slot == ring_slot_q);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    load_slot_ok = 1'b0;
    rd_d         = '0;
    match_hit    = 1'b0;
    match_idx    = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (load_slot == SLOT_W'(i)) load_slot_ok = 1'b1;
      if (read_slot == SLOT_W'(i)) rd_d = slot_q[i];
    end
    if (load_valid && (load_slot == read_slot)) rd_d = new_time;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (en_q[i] && (slot_q[i] == cur_time)) begin
        match_hit = 1'b1;
        match_idx = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the slot memory is reset because a cleared, disabled bank is the defined start state.
      for (int i = 0; i < N_ALARMS; i++) slot_q[i] <= '0;
      en_q  <= '0;
      rd_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ack_q <= load_valid;
      err_q <= load_new_alarm && !load_valid;
      rd_q  <= rd_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        if (load_slot == SLOT_W'(i)) begin
          if (load_valid) begin
            slot_q[i] <= new_time;
            en_q[i]   <= 1'b1;
          end else if (!load_new_alarm && enable_wr) begin
            en_q[i]   <= enable_val;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ring_q       <= 1'b0;
      ring_slot_q  <= '0;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (one_minute && match_hit) begin
            state_q     <= ST_RINGING;
            ring_q      <= 1'b1;
            ring_slot_q <= match_idx;
            ring_cnt_q  <= '0;
          end
        end
        ST_RINGING: begin
          if (stop_alarm || disarm_ring) begin
            state_q <= ST_IDLE;
            ring_q  <= 1'b0;
          end else if (snooze) begin
            state_q      <= ST_SNOOZE;
            ring_q       <= 1'b0;
            snooze_cnt_q <= SNOOZE_LEN;
          end else if (one_minute) begin
            if (ring_cnt_q + 4'd1 == RING_LIMIT) begin
              state_q    <= ST_IDLE;
              ring_q     <= 1'b0;
              ring_cnt_q <= '0;
            end else begin
              ring_cnt_q <= ring_cnt_q + 4'd1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_alarm || disarm_ring) begin
            state_q <= ST_IDLE;
            ring_q  <= 1'b0;
          end else if (one_minute) begin
            if (snooze_cnt_q == 4'd1) begin
              state_q      <= ST_RINGING;
              ring_q       <= 1'b1;
              ring_cnt_q   <= '0;
              snooze_cnt_q <= '0;
            end else begin
              snooze_cnt_q <= snooze_cnt_q - 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = rd_q;
  assign alarm_ring = ring_q;
  assign ring_slot  = ring_slot_q;
  assign load_ack   = ack_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: directed walk through the alarm scenarios, then random
// traffic, all compared cycle by cycle with a minutes-of-day reference model.
module tb_alarm_bank;

  localparam int N   = 4;
  localparam int SW  = 3;
  localparam int SNZ = 5;
  localparam int RTO = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_new_alarm;
  logic [SW-1:0] load_slot;
  logic [3:0]    new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
  logic          enable_wr, enable_val;
  logic [SW-1:0] read_slot;
  logic [3:0]    cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
  logic          one_minute, stop_alarm, snooze;
  logic [3:0]    at_ms_hr, at_ls_hr, at_ms_min, at_ls_min;
  logic          alarm_ring;
  logic [SW-1:0] ring_slot;
  logic          load_ack, load_err;

  always #5 clock = ~clock;

  alarm_bank #(
    .N_ALARMS(N), .SLOT_W(SW), .SNOOZE_MIN(SNZ), .RING_TIMEOUT(RTO)
  ) dut (
    .clock(clock), .reset(reset),
    .load_new_alarm(load_new_alarm), .load_slot(load_slot),
    .new_alarm_ms_hr(new_ms_hr), .new_alarm_ls_hr(new_ls_hr),
    .new_alarm_ms_min(new_ms_min), .new_alarm_ls_min(new_ls_min),
    .enable_wr(enable_wr), .enable_val(enable_val), .read_slot(read_slot),
    .current_time_ms_hr(cur_ms_hr), .current_time_ls_hr(cur_ls_hr),
    .current_time_ms_min(cur_ms_min), .current_time_ls_min(cur_ls_min),
    .one_minute(one_minute), .stop_alarm(stop_alarm), .snooze(snooze),
    .alarm_time_ms_hr(at_ms_hr), .alarm_time_ls_hr(at_ls_hr),
    .alarm_time_ms_min(at_ms_min), .alarm_time_ls_min(at_ls_min),
    .alarm_ring(alarm_ring), .ring_slot(ring_slot),
    .load_ack(load_ack), .load_err(load_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: alarm times held as minutes since midnight.
  typedef enum int {M_IDLE, M_RING, M_SNZ} mode_e;
  int      m_time [N];
  bit      m_en   [N];
  mode_e   m_mode;
  int      m_rslot, m_rung, m_snz_left;
  logic          e_ring, e_ack, e_err;
  logic [SW-1:0] e_slot;
  logic [15:0]   e_rb;

  function automatic logic [15:0] to_digits(input int t);
    int hr = t / 60;
    int mn = t % 60;
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10)};
  endfunction

  task automatic model_step();
    int  hit = -1;
    int  hr, mn, newt, curt;
    bit  valid, dis;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_time[i] = 0;
        m_en[i]   = 1'b0;
      end
      m_mode = M_IDLE; m_rslot = 0; m_rung = 0; m_snz_left = 0;
      e_ring = 1'b0; e_slot = '0; e_ack = 1'b0; e_err = 1'b0; e_rb = '0;
      return;
    end
    hr    = int'(new_ms_hr) * 10 + int'(new_ls_hr);
    mn    = int'(new_ms_min) * 10 + int'(new_ls_min);
    newt  = hr * 60 + mn;
    valid = (new_ls_hr <= 4'd9) && (new_ls_min <= 4'd9) && (new_ms_min <= 4'd9) &&
            (hr < 24) && (mn < 60) && (int'(load_slot) < N);
    curt  = (int'(cur_ms_hr) * 10 + int'(cur_ls_hr)) * 60 +
            int'(cur_ms_min) * 10 + int'(cur_ls_min);
    for (int i = N - 1; i >= 0; i--)
      if (m_en[i] && (m_time[i] == curt)) hit = i;
    dis = !load_new_alarm && enable_wr && !enable_val && (int'(load_slot) == m_rslot);

    if (int'(read_slot) >= N)                                    e_rb = '0;
    else if (load_new_alarm && valid && (load_slot == read_slot)) e_rb = to_digits(newt);
    else                                                         e_rb = to_digits(m_time[int'(read_slot)]);

    case (m_mode)
      M_IDLE: if (one_minute && hit >= 0) begin
        m_mode = M_RING; m_rslot = hit; m_rung = 0;
      end
      M_RING: begin
        if (stop_alarm || dis) m_mode = M_IDLE;
        else if (snooze) begin
          m_mode = M_SNZ; m_snz_left = SNZ;
        end else if (one_minute) begin
          m_rung++;
          if (m_rung == RTO) m_mode = M_IDLE;
        end
      end
      default: begin
        if (stop_alarm || dis) m_mode = M_IDLE;
        else if (one_minute) begin
          m_snz_left--;
          if (m_snz_left == 0) begin
            m_mode = M_RING; m_rung = 0;
          end
        end
      end
    endcase

    if (load_new_alarm) begin
      if (valid) begin
        m_time[int'(load_slot)] = newt;
        m_en[int'(load_slot)]   = 1'b1;
      end
    end else if (enable_wr && int'(load_slot) < N) begin
      m_en[int'(load_slot)] = enable_val;
    end
    e_ack  = load_new_alarm && valid;
    e_err  = load_new_alarm && !valid;
    e_ring = (m_mode == M_RING);
    e_slot = SW'(m_rslot);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same inputs, outputs sampled at the falling edge.
  task automatic step();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check("alarm_ring", 32'(alarm_ring), 32'(e_ring));
    check("ring_slot",  32'(ring_slot),  32'(e_slot));
    check("load_ack",   32'(load_ack),   32'(e_ack));
    check("load_err",   32'(load_err),   32'(e_err));
    check("readback",   32'({at_ms_hr, at_ls_hr, at_ms_min, at_ls_min}), 32'(e_rb));
  endtask

  task automatic do_load(input int s, input logic [3:0] a, b, c, d);
    load_new_alarm = 1'b1;
    load_slot = SW'(s);
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = {a, b, c, d};
    step();
    load_new_alarm = 1'b0;
  endtask

  task automatic do_en(input int s, input logic v);
    enable_wr = 1'b1; enable_val = v; load_slot = SW'(s);
    step();
    enable_wr = 1'b0;
  endtask

  task automatic do_tick(input logic [3:0] a, b, c, d);
    one_minute = 1'b1;
    {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = {a, b, c, d};
    step();
    one_minute = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_new_alarm = 1'b0; load_slot = '0; enable_wr = 1'b0; enable_val = 1'b0;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = '0;
    {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = '0;
    read_slot = '0; one_minute = 1'b0; stop_alarm = 1'b0; snooze = 1'b0;

    step(); step();
    reset = 1'b0;
    step();
    check("rst_ring", 32'(alarm_ring), 32'd0);
    check("rst_rb", 32'({at_ms_hr, at_ls_hr, at_ms_min, at_ls_min}), 32'd0);

    // Valid load and readback.
    read_slot = 3'd1;
    do_load(1, 4'd0, 4'd7, 4'd3, 4'd0);
    check("ld_ack", 32'(load_ack), 32'd1);
    step();
    check("ld_ack_drop", 32'(load_ack), 32'd0);
    check("ld_rb", 32'({at_ms_hr, at_ls_hr, at_ms_min, at_ls_min}), 32'h0730);

    // Rejected loads: 24:00, 19:60, 2A:00, slot 5.
    read_slot = 3'd0;
    do_load(0, 4'd2, 4'd4, 4'd0, 4'd0);  check("err_24h", 32'(load_err), 32'd1);
    do_load(0, 4'd1, 4'd9, 4'd6, 4'd0);  check("err_60m", 32'(load_err), 32'd1);
    do_load(0, 4'd2, 4'hA, 4'd0, 4'd0);  check("err_2A",  32'(load_err), 32'd1);
    do_load(5, 4'd0, 4'd8, 4'd0, 4'd0);  check("err_slot", 32'(load_err), 32'd1);
    step();
    check("err_rb0", 32'({at_ms_hr, at_ls_hr, at_ms_min, at_ls_min}), 32'd0);

    // Two slots match; lowest wins; auto-stop after the third later tick.
    do_load(0, 4'd0, 4'd6, 4'd1, 4'd5);
    do_load(2, 4'd0, 4'd6, 4'd1, 4'd5);
    do_tick(4'd0, 4'd6, 4'd1, 4'd5);
    check("match_ring", 32'(alarm_ring), 32'd1);
    check("match_slot", 32'(ring_slot), 32'd0);
    do_tick(4'd0, 4'd6, 4'd1, 4'd6);
    do_tick(4'd0, 4'd6, 4'd1, 4'd7);
    check("tmo_still", 32'(alarm_ring), 32'd1);
    do_tick(4'd0, 4'd6, 4'd1, 4'd8);
    check("tmo_stop", 32'(alarm_ring), 32'd0);

    // Snooze on slot 2, resume on the fifth tick, then stop+snooze together.
    do_en(0, 1'b0);
    do_tick(4'd0, 4'd6, 4'd1, 4'd5);
    check("s2_slot", 32'(ring_slot), 32'd2);
    snooze = 1'b1; step(); snooze = 1'b0;
    check("snz_quiet", 32'(alarm_ring), 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_tick(4'd0, 4'd6, 4'd2, 4'd0);
      check("snz_hold", 32'(alarm_ring), 32'd0);
    end
    do_tick(4'd0, 4'd6, 4'd2, 4'd0);
    check("snz_resume", 32'(alarm_ring), 32'd1);
    check("snz_slot", 32'(ring_slot), 32'd2);
    stop_alarm = 1'b1; snooze = 1'b1; step(); stop_alarm = 1'b0; snooze = 1'b0;
    check("stop_wins", 32'(alarm_ring), 32'd0);
    step();
    check("stop_idle", 32'(alarm_ring), 32'd0);

    // Disabled slot stays silent; disarming the ringing slot stops it.
    do_load(3, 4'd1, 4'd2, 4'd0, 4'd0);
    do_en(3, 1'b0);
    do_tick(4'd1, 4'd2, 4'd0, 4'd0);
    check("dis_silent", 32'(alarm_ring), 32'd0);
    do_en(3, 1'b1);
    do_tick(4'd1, 4'd2, 4'd0, 4'd0);
    check("en_ring", 32'(alarm_ring), 32'd1);
    check("en_slot", 32'(ring_slot), 32'd3);
    do_en(3, 1'b0);
    check("disarm", 32'(alarm_ring), 32'd0);

    // Reset while ringing clears everything.
    do_en(3, 1'b1);
    do_tick(4'd1, 4'd2, 4'd0, 4'd0);
    check("pre_rst_ring", 32'(alarm_ring), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_ring", 32'(alarm_ring), 32'd0);
    read_slot = 3'd3; step();
    check("rst_rb3", 32'({at_ms_hr, at_ls_hr, at_ms_min, at_ls_min}), 32'd0);
    do_tick(4'd1, 4'd2, 4'd0, 4'd0);
    check("rst_no_ring", 32'(alarm_ring), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset          = ($urandom_range(0, 299) == 0);
      load_new_alarm = ($urandom_range(0, 6) == 0);
      load_slot      = ($urandom_range(0, 5) == 0) ? SW'($urandom_range(4, 7)) : SW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = to_digits(int'($urandom_range(0, 1439)));
      else
        {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = 16'($urandom);
      enable_wr  = ($urandom_range(0, 5) == 0);
      enable_val = 1'($urandom);
      read_slot  = SW'($urandom_range(0, 7));
      one_minute = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0)
        {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = to_digits(m_time[$urandom_range(0, N - 1)]);
      else
        {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = to_digits(int'($urandom_range(0, 1439)));
      stop_alarm = ($urandom_range(0, 24) == 0);
      snooze     = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-slot successor to the single alarm register in the alarm-clock datapath.
- Holds N_ALARMS BCD alarm times (HH:MM, 24 h), each with its own enable bit, and validates every load.
- Compares enabled slots against the current time on each minute tick and drives the alarm through a ring/snooze/timeout state machine.
- Sits between the key/load FSM and the time counter on the input side, and the display mux/sounder on the output side.

Parameters:
N_ALARMS, 4, number of alarm slots (2..8)
SLOT_W, 2, width of slot index; must satisfy 2**SLOT_W >= N_ALARMS
SNOOZE_MIN, 5, snooze length in minute ticks (1..15)
RING_TIMEOUT, 3, minute ticks of unattended ringing before auto-stop (1..15)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_new_alarm  input  1  write new_alarm_* into slot load_slot and set its enable
load_slot  input  SLOT_W  target slot for load/enable writes
new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  input  4 each  BCD alarm digits
enable_wr  input  1  write enable_val into enable bit of load_slot
enable_val  input  1  enable value for enable_wr
read_slot  input  SLOT_W  slot selected for readback
current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  input  4 each  BCD time from time counter
one_minute  input  1  single-cycle minute strobe, qualifies current_time_*
stop_alarm  input  1  stop ringing/snooze
snooze  input  1  snooze request
alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min  output  4 each  registered readback of read_slot
alarm_ring  output  1  sounder drive
ring_slot  output  SLOT_W  slot that triggered current ring/snooze
load_ack  output  1  one-cycle pulse, load accepted
load_err  output  1  one-cycle pulse, load rejected

Behaviour:
- Reset: all slots 0000 (00:00), all enables 0, FSM IDLE, alarm_ring 0, ring_slot 0, load_ack 0, load_err 0, alarm_time_* 0, counters 0. Reset has priority over all inputs. Reset mid-ring stops the ring on the next edge.
- Load validity: ms_hr<=2, ls_hr<=9, (ms_hr==2 implies ls_hr<=3), ms_min<=5, ls_min<=9, load_slot<N_ALARMS.
- Valid load: slot is written and its enable set to 1 on that edge; load_ack=1 for the following cycle.
- Invalid load: no state change; load_err=1 for the following cycle. Holding load_new_alarm high gives one ack/err per cycle.
- enable_wr (load_new_alarm low): writes enable_val into the enable bit of load_slot, no ack/err. Out-of-range slot is ignored.
- enable_wr together with load_new_alarm: the load takes precedence (enable=1 if valid).
- Readback: alarm_time_* reflect the slot selected by read_slot with 1-cycle latency, and the value written by a load on the following cycle. Out-of-range read_slot returns 0.
- Match: evaluated only in cycles with one_minute=1. A slot matches when it is enabled and all four digits equal current_time_*. Lowest matching index wins. Slot contents before the same-edge load are used.
- FSM, IDLE: on a match, go to RINGING; alarm_ring=1 and ring_slot=index from the next cycle; ring_cnt cleared.
- FSM, RINGING:
  - stop_alarm: go to IDLE, alarm_ring=0 next cycle.
  - Else snooze: go to SNOOZE, alarm_ring=0, snooze_cnt=SNOOZE_MIN.
  - Else one_minute: ring_cnt increments; when it reaches RING_TIMEOUT, go to IDLE.
  - New matches are ignored.
- FSM, SNOOZE:
  - stop_alarm: go to IDLE.
  - one_minute: snooze_cnt decrements; on the tick where it goes 1->0, go to RINGING (alarm_ring=1 next cycle, ring_cnt cleared, ring_slot unchanged).
  - snooze is ignored; new matches are ignored.
- stop_alarm and snooze in the same cycle: stop wins.
- Writing enable=0 to ring_slot while in RINGING or SNOOZE: go to IDLE next cycle. Reloading that slot with a valid time does not affect the FSM.
- Return to IDLE never re-triggers in the same minute: matching resumes at the next one_minute.

Test Plan:
- Reset, then load slot 1 = 07:30 -> load_ack pulse 1 cycle; read_slot=1 gives alarm_time_* 0,7,3,0 after 1 cycle; enable[1]=1.
- Loads 24:00, 19:60, 2A:00 to slot 0, and a valid load to slot 5 (N_ALARMS=4, SLOT_W=3) -> load_err pulse each; slot 0 readback stays 00:00.
- Slots 0 and 2 both 06:15 and enabled; one_minute with time 06:15 -> alarm_ring=1, ring_slot=0. No stop input -> alarm_ring=0 after the 3rd subsequent one_minute.
- Ring on slot 2, pulse snooze -> ring 0; 4 one_minute ticks keep ring 0; 5th tick -> ring=1, ring_slot=2. Then stop_alarm+snooze in the same cycle -> IDLE, ring 0.
- Slot 3 = 12:00 with enable_wr 0 -> no ring at 12:00. Re-enable, ring at next matching tick, then enable_wr 0 on slot 3 while ringing -> ring 0 next cycle.
- Assert reset while RINGING -> alarm_ring 0, all readbacks 00:00, enables cleared, so no ring at the following matching tick.
